// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame size and
// the FIFO level width helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int FRAME_BITS = 10;

    // The level must be able to hold FIFO_DEPTH itself, not just DEPTH-1.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Small synchronous FIFO. Full/empty come from the occupancy count, so the
// pointers are free to wrap modulo FIFO_DEPTH.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DATA_W-1:0]                 din,
    output logic [DATA_W-1:0]                 dout,
    output logic [level_w(FIFO_DEPTH)-1:0]    level,
    output logic                              full,
    output logic                              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = level_w(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == LW'(FIFO_DEPTH));
    assign empty = (r_level == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter through valid/ready into a FIFO
// and are serialised LSB first on a registered tx line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 87,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [level_w(FIFO_DEPTH)-1:0]    fifo_level
);
    localparam int BW = $clog2(CLK_DIV);
    localparam int NB = FRAME_BITS - 2;
    localparam int CW = $clog2(NB);

    logic [1:0]        r_state;
    logic [BW-1:0]     r_baud;
    logic [CW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_busy;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_dout;

    assign w_push    = in_valid && !w_full;
    assign w_bit_end = (r_baud == BW'(CLK_DIV - 1));
    // Popping on the last stop cycle chains frames with no idle gap.
    assign w_pop     = !w_empty && ena &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .dout  (w_dout),
        .level (fifo_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_shift <= w_dout;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == CW'(NB - 1)) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_shift <= w_dout;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready = !w_full;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed tables and sequences plus randomized
// traffic checked every cycle against a frame-timing reference model.
module tb_uart_tx_fifo;
    localparam int CD    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    // Reference model: queue of bytes plus the time left in the frame on the line.
    byte unsigned m_q[$];
    int           m_left = 0;
    int           m_pos  = 0;
    logic [7:0]   m_cur  = 8'h00;
    bit           m_pushed = 1'b0;
    bit           m_popped = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_left   = 0;
        m_pos    = 0;
        m_pushed = 1'b0;
        m_popped = 1'b0;
    endtask

    task automatic model_step();
        bit pu, po;
        pu = in_valid && (m_q.size() < DEPTH);
        po = ena && (m_q.size() > 0) && (m_left <= 1);
        if (po) begin
            m_cur  = m_q.pop_front();
            m_left = 10 * CD;
            m_pos  = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_pos++;
        end
        if (pu) m_q.push_back(in_data);
        m_pushed = pu;
        m_popped = po;
    endtask

    function automatic logic model_tx();
        int b;
        if (m_left == 0) return 1'b1;
        b = m_pos / CD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check("model_tx", tx, model_tx());
        check("model_busy", busy, m_left > 0);
        check("model_ready", in_ready, m_q.size() != DEPTH);
        check("model_level", fifo_level, m_q.size());
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic [2:0] lvl;
    } vec_t;

    vec_t tbl[6];
    int   a5_bits[10];
    bit   seen;
    logic pre_rdy;
    int   rate;

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b1, 3'd1};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 3'd2};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 3'd3};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd4};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 3'd4};
        tbl[5] = '{1'b1, 8'h55, 1'b0, 3'd4};
        a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        rst = 1'b0;

        // Single frame 0xA5
        ena = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        check("a5_pre_tx", tx, 1);
        check("a5_pre_level", fifo_level, 1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("a5_bit", tx, a5_bits[i/CD]);
            check("a5_busy", busy, 1);
        end
        tick();
        check("a5_end_busy", busy, 0);
        check("a5_end_tx", tx, 1);

        // Backpressure with ena low
        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d;
            tick();
            check("bp_ready", in_ready, tbl[i].rdy);
            check("bp_level", fifo_level, tbl[i].lvl);
            check("bp_tx", tx, 1);
            check("bp_busy", busy, 0);
        end

        // Back-to-back frames; 0x55 still held by the source
        ena = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_pushed) in_valid = 1'b0;
            if (i == 0) begin
                check("b2b_level_pop", fifo_level, 3);
                check("b2b_ready_pop", in_ready, 1);
            end
            if (i == 1) check("b2b_level_55", fifo_level, 4);
            check("b2b_busy", busy, 1);
        end
        tick();
        check("b2b_end_busy", busy, 0);
        check("b2b_end_level", fifo_level, 0);

        // Reset mid-frame at frame cycle 15
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        repeat (15) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_level", fifo_level, 0);
        model_reset();
        tick();
        rst = 1'b0;
        repeat (50) tick();
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", busy, 0);

        // Reset pulse between edges during a start bit
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        check("sb_tx_low", tx, 0);
        rst = 1'b1;
        #1;
        check("async_tx", tx, 1);
        check("async_busy", busy, 0);
        check("async_ready", in_ready, 1);
        model_reset();
        #1;
        rst = 1'b0;
        repeat (50) tick();

        // Push and pop on the same edge at level 1
        ena = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        ena = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        check("simul_level", fifo_level, 1);
        check("simul_tx", tx, 0);

        // ena drops mid-frame: frame completes, next one waits
        repeat (9) tick();
        ena = 1'b0;
        repeat (30) tick();
        check("ena_last_busy", busy, 1);
        tick();
        check("ena_done_busy", busy, 0);
        check("ena_done_level", fifo_level, 1);
        repeat (5) tick();
        check("ena_hold_tx", tx, 1);
        ena = 1'b1;
        tick();
        check("ena_resume_tx", tx, 0);
        check("ena_resume_level", fifo_level, 0);

        // Full FIFO with source held through the pop cycle
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(k);
            tick();
        end
        in_data = 8'h99;
        check("full_ready", in_ready, 0);
        check("full_level", fifo_level, 4);
        seen = 1'b0; pre_rdy = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            pre_rdy = in_ready;
            tick();
            if (m_popped) seen = 1'b1;
        end
        check("full_pop_seen", seen, 1);
        check("full_pop_rdy_pre", pre_rdy, 0);
        check("full_pop_level", fifo_level, 3);
        tick();
        in_valid = 1'b0;
        check("full_push_level", fifo_level, 4);
        check("full_push_ready", in_ready, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rate = (n < 1500) ? 3 : 50;
            if (!in_valid || m_pushed) begin
                in_valid = ($urandom_range(0, rate) == 0);
                in_data  = 8'($urandom);
            end
            ena = ($urandom_range(0, 9) != 0);
            tick();
        end
        in_valid = 1'b0; ena = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            tick();
            if (m_left == 0 && m_q.size() == 0) seen = 1'b1;
        end
        check("drain_done", seen, 1);
        check("drain_busy", busy, 0);
        check("drain_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Downstream output stage inside tt_um_loop_mackman18. It takes 8-bit result bytes from the loop core through a valid/ready handshake and buffers them in a small FIFO. It serialises each byte as 8N1 UART on one pin, which the top level routes to uo_out[0]. This lets the cocotb bench and silicon read core results over a single wire.

Parameters:
CLK_DIV, 87, clock cycles per UART bit (10 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, FIFO entries; must be a power of 2, at least 2
DATA_W, 8, payload width per frame; fixed at 8 for 8N1

Ports:
clk  input  1  system clock; the top-level clk
rst  input  1  asynchronous, active-high reset; the top level drives it as ~rst_n
ena  input  1  design enable; when low, no new frame starts
in_data  input  8  byte from the loop core
in_valid  input  1  in_data is valid
in_ready  output  1  FIFO can accept a byte; equals !full
tx  output  1  UART serial line; idles high
busy  output  1  high while a frame is on the line
fifo_level  output  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, busy=0, in_ready=1, fifo_level=0.
  - FIFO pointers, baud counter and bit counter cleared; state=IDLE.
  - Asserting rst mid-frame aborts the frame immediately; tx goes high without waiting for a clock edge.
- Push:
  - A byte is written on a rising edge where in_valid && in_ready.
  - in_ready is derived from the registered count only: in_ready = (fifo_level != FIFO_DEPTH).
- Pop:
  - Happens internally when state=IDLE or on the final cycle of STOP, provided fifo_level>0 and ena=1.
  - The popped byte is loaded into the shift register.
- Simultaneous push and pop in the same cycle: fifo_level is unchanged and the data is correct.
  - Push into a full FIFO is impossible, because in_ready=0.
  - Pop from an empty FIFO does not occur.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the edge where a pop occurs. tx<=0 and busy<=1 on that same edge.
  - START holds for CLK_DIV cycles, then -> DATA with tx<=shift[0].
  - DATA sends 8 bits LSB first, each for CLK_DIV cycles; bit counter runs 0..7. After bit 7 -> STOP with tx<=1.
  - STOP holds for CLK_DIV cycles.
    - On its last cycle, if a pop condition holds -> START directly. There is no idle gap between frames.
    - Otherwise -> IDLE with busy<=0.
- Timing: tx is registered. Latency from a push into an empty FIFO (ena=1, IDLE) to the falling edge of tx is 2 clocks. One frame is exactly 10*CLK_DIV cycles.
- Baud counter: counts 0..CLK_DIV-1 and reloads at each bit boundary.
- ena:
  - Sampled only at pop decisions.
  - ena=0 mid-frame lets the current frame complete.
  - ena=0 does not block pushes.

Decomposition:
- uart_pkg holds:
  - the state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - FRAME_BITS=10;
  - the level-width function.
- One sub-module, sync_fifo:
  - parameterised on DATA_W and FIFO_DEPTH;
  - ports: push, pop, din, dout, level, full, empty;
  - dout is combinational from the read pointer.
- The FSM, baud counter and shifter live in uart_tx_fifo.

Test Plan:
(All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.)
1. Reset: assert rst for 3 cycles -> tx=1, busy=0, in_ready=1, fifo_level=0. Pulse rst between clock edges -> outputs respond without waiting for an edge.
2. Single frame: push 0xA5 with ena=1 -> tx goes low 2 clocks later. Bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy stays high for 40 cycles, then drops.
3. Backpressure: ena=0, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> in_ready=0 after the 4th push. fifo_level=4. 0x55 is held by the source. tx stays 1.
4. Back-to-back frames: then raise ena -> frames 0x11,0x22,0x33,0x44 emitted in order. There is no idle cycle between each stop bit and the next start bit, and 0x55 is accepted once the first pop frees a slot. All five frames take 200 cycles total. busy stays continuously high.
5. Reset mid-frame: push 0xFF, assert rst at cycle 15 of the frame -> tx=1 immediately, fifo_level=0, busy=0. After deassert, no residual frame is emitted.
6. Simultaneous events, ena timing and full-FIFO push/pop:
   - With fifo_level=1, push on the same cycle as an internal pop -> fifo_level stays 1.
   - ena falls mid-frame -> the current frame completes and no further frame starts until ena returns.
   - With the FIFO full, hold in_valid through the pop cycle -> in_ready stays 0 on that cycle and the byte is written on the next edge.
